multi_digit_seg_ctrl: RTL and testbench
=======================================

# multi_digit_seg_ctrl

- Parametrised successor to the quad seven-segment controller: time-multiplexes `NUM_DIGITS` common-anode hex digits with per-digit decimal point and per-digit blanking.
- Display data is double-buffered: a `load` pulse captures new data, which is swapped in only at a frame boundary, so a frame never shows a mix of old and new data.
- Optional PWM brightness control.
- Sits between the system's register/status logic and the board's anode/cathode pins.

## Interface
- `NUM_DIGITS`, default 4: digits driven, legal 2..8.
- `CLK_DIV`, default 50000: clk cycles per digit slot; must be a multiple of 8 and ≥ 16.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `load` in 1: one-cycle strobe; captures `val_in`, `dot_in`, `blank_in` into the shadow buffer.
- `val_in` in 4*NUM_DIGITS: hex nibbles; digit k = `val_in[4k+3:4k]`.
- `dot_in` in NUM_DIGITS: 1 = dp lit for digit k.
- `blank_in` in NUM_DIGITS: 1 = digit k dark.
- `brightness` in 3: duty level, 0 = 1/8 … 7 = 8/8.
- `an` out NUM_DIGITS: anode enables, active-low; `an[k]` drives digit k.
- `seg` out 7: cathodes, active-low; `seg[6]` = a … `seg[0]` = g.
- `dp` out 1: decimal-point cathode, active-low.
- `busy` out 1: shadow holds data not yet displayed.
- `frame_tick` out 1: one-cycle pulse when a frame completes.

## Operation
- **Slot timing:** `div_cnt` counts 0..CLK_DIV-1 and wraps. `digit` counts 0..NUM_DIGITS-1 and advances when `div_cnt` == CLK_DIV-1; it wraps from NUM_DIGITS-1 to 0.
- **Frame end:** `div_cnt` == CLK_DIV-1 and `digit` == NUM_DIGITS-1.
- **Shadow buffer:** `load` writes the shadow registers and sets `pending`.
  - A load while `pending` is set overwrites the shadow; the latest load wins.
- **Swap:** at frame end with `pending` set and `load` low: active ← shadow and `pending` clears.
  - If `load` is high in the same cycle, the load is captured, `pending` stays set, and the swap defers to the next frame end.
- `busy` = `pending` (registered).
- **Decode (active-low, seg order a..g):**
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- **Lit condition:** current digit not blanked AND the duty condition holds.
  - Lit: `an[digit]` = 0, all other anodes = 1, `seg` = decode(active value), `dp` = ~active dot.
  - Not lit: `an` all 1, `seg` = 7'h7F, `dp` = 1.
- **Duty condition:** see Configuration.

## Timing
- All outputs are registered. `an`/`seg`/`dp` reflect the `div_cnt`/`digit` state of the previous cycle, so each slot is CLK_DIV cycles long and lags the counters by 1 cycle.
- **Frame timing:**
  - `frame_tick` is high for the one cycle after each frame end, whether or not a swap occurred.
  - Frame period = NUM_DIGITS*CLK_DIV cycles.
- **Swap timing:**
  - The swapped data is first visible on the outputs in the digit-0 slot of the new frame.
  - `busy` falls in the same cycle that `frame_tick` rises.
  - `load` → `busy` high: 1 cycle.
- **Reset values** (`rst` sampled high on any cycle, including mid-frame or with `pending` set):
  - Outputs: `an` all 1, `seg` 7'h7F, `dp` 1, `busy` 0, `frame_tick` 0.
  - Internal: `div_cnt` 0, `digit` 0, `pending` 0.
  - Registers: active/shadow values 0, dots 0, blanks all 1, so the display is dark until the first load is swapped in.
  - A `load` in a reset cycle is ignored.
- **Input sampling:** `brightness` is sampled every cycle, so changes take effect mid-slot.

## Configuration
- Macro: `SEG_DIM_PWM_EN`.
- **Defined:** the duty condition is `div_cnt` < (`brightness`+1)*(CLK_DIV/8).
  - `brightness` 7 = always on within the slot.
  - `brightness` 0 = first CLK_DIV/8 cycles of each slot only.
- **Undefined:** the duty condition is always true, `brightness` is unused (no logic), and every non-blanked slot is fully lit.

## Test plan
All scenarios use NUM_DIGITS=4, CLK_DIV=16.

- **Reset:** hold `rst` 3 cycles, release, run 64 cycles → `an`=4'hF, `seg`=7'h7F, `dp`=1, `busy`=0 throughout; `frame_tick` pulses every 64 cycles.
- **Basic load:** `load` with `val_in`=16'h8F30, `dot_in`=4'b0100, `blank_in`=0 mid-frame → `busy`=1 until frame end.
  - Next frame slots: an=1110 seg=0000001 dp=1; an=1101 seg=0000110 dp=1; an=1011 seg=0111000 dp=0; an=0111 seg=0000000 dp=1.
- **Double load:** two loads (16'h1111, then 16'h2222) within one frame → only 2222 appears (seg=0010010); the 1111 pattern is never displayed.
- **Load at swap:** `load` coincident with frame end → `busy` stays 1, swap occurs one frame later, `frame_tick` still pulses at the first frame end.
- **Blanking and mid-frame reset:** `blank_in`=4'b1010 → slots 1 and 3 show `an`=4'hF, `seg`=7'h7F. Assert `rst` at slot 2 → all outputs dark on the next cycle; `busy`=0.
- **PWM (`SEG_DIM_PWM_EN` defined):** `brightness`=1 → each lit slot has the anode low for exactly 4 of 16 cycles (slot cycles 0–3). `brightness`=7 → low for all 16 cycles.

Source files
------------

// File: rtl/multi_digit_seg_ctrl.sv
// -----------------------------------------------------------------------------
// multi_digit_seg_ctrl
//
// Time-multiplexed driver for NUM_DIGITS common-anode hex digits with a
// per-digit decimal point and per-digit blanking. New display data is
// captured into a shadow buffer on a load strobe and copied to the active
// buffer only at a frame boundary, so a frame never mixes old and new data.
//
// Optional feature macro: SEG_DIM_PWM_EN
//   defined   -> each slot is lit only for the first
//                (brightness+1)*(CLK_DIV/8) cycles.
//   undefined -> every non-blanked slot is fully lit; brightness is ignored.
//
// Parameters:
//   NUM_DIGITS  digits driven (2..8)
//   CLK_DIV     clk cycles per digit slot (multiple of 8, >= 16)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   load        one-cycle strobe capturing val_in/dot_in/blank_in
//   val_in      hex nibbles, digit k = val_in[4k+3:4k]
//   dot_in      1 = decimal point lit for digit k
//   blank_in    1 = digit k dark
//   brightness  duty level, 0 = 1/8 .. 7 = 8/8 (PWM build only)
//   an          anode enables, active-low, an[k] drives digit k
//   seg         cathodes a..g on seg[6]..seg[0], active-low
//   dp          decimal-point cathode, active-low
//   busy        shadow holds data not yet displayed
//   frame_tick  one-cycle pulse after each frame end
// -----------------------------------------------------------------------------
module multi_digit_seg_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic [NUM_DIGITS-1:0]   dot_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [2:0]              brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    busy,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [DIG_W-1:0]      DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIGIT_ONE = NUM_DIGITS'(1);

    logic [CNT_W-1:0]        div_cnt;
    logic [DIG_W-1:0]        digit;
    logic                    pending;

    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dot;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic [4*NUM_DIGITS-1:0] active_val;
    logic [NUM_DIGITS-1:0]   active_dot;
    logic [NUM_DIGITS-1:0]   active_blank;

    logic                    slot_end;
    logic                    frame_end;
    logic                    duty;
    logic                    lit;
    logic [3:0]              cur_val;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;

    // Active-low a..g patterns for the 16 hex glyphs.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0:    decode = 7'b0000001;
            4'h1:    decode = 7'b1001111;
            4'h2:    decode = 7'b0010010;
            4'h3:    decode = 7'b0000110;
            4'h4:    decode = 7'b1001100;
            4'h5:    decode = 7'b0100100;
            4'h6:    decode = 7'b0100000;
            4'h7:    decode = 7'b0001111;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0000100;
            4'hA:    decode = 7'b0001000;
            4'hB:    decode = 7'b1100000;
            4'hC:    decode = 7'b0110001;
            4'hD:    decode = 7'b1000010;
            4'hE:    decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

    assign slot_end  = (div_cnt == CNT_LAST);
    assign frame_end = slot_end && (digit == DIG_LAST);
    assign busy      = pending;

`ifdef SEG_DIM_PWM_EN
    // Lit window grows in steps of CLK_DIV/8; level 7 covers the whole slot.
    assign duty = (32'(div_cnt) < ((32'(brightness) + 32'd1) * 32'(CLK_DIV / 8)));
`else
    // Brightness is ignored in the full-duty build.
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign duty = 1'b1;
`endif

    // Next-cycle pin values for the digit currently selected by the counters.
    always_comb begin
        cur_val  = active_val[{digit, 2'b00} +: 4];
        lit      = ~active_blank[digit] & duty;
        an_next  = '1;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (lit) begin
            an_next  = ~(DIGIT_ONE << digit);
            seg_next = decode(cur_val);
            dp_next  = ~active_dot[digit];
        end
    end

    // Slot/digit counters, double buffer with deferred swap, registered pins.
    // A load in the frame-end cycle wins over the swap so the newest data is
    // never lost; the swap then happens one frame later.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= '0;
            digit        <= '0;
            pending      <= 1'b0;
            shadow_val   <= '0;
            shadow_dot   <= '0;
            shadow_blank <= '1;
            active_val   <= '0;
            active_dot   <= '0;
            active_blank <= '1;
            an           <= '1;
            seg          <= 7'h7F;
            dp           <= 1'b1;
            frame_tick   <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_tick <= frame_end;

            if (slot_end) begin
                div_cnt <= '0;
                digit   <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (load) begin
                shadow_val   <= val_in;
                shadow_dot   <= dot_in;
                shadow_blank <= blank_in;
                pending      <= 1'b1;
            end else if (frame_end && pending) begin
                active_val   <= shadow_val;
                active_dot   <= shadow_dot;
                active_blank <= shadow_blank;
                pending      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_digit_seg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_digit_seg_ctrl
//
// Directed self-checking bench for multi_digit_seg_ctrl with NUM_DIGITS=4,
// CLK_DIV=16. Inputs change and outputs are sampled on the falling edge.
// A frame_tick seen at falling edge T means the output at T+1+16k+c shows
// slot k, slot cycle c of the new frame.
// -----------------------------------------------------------------------------
module tb_multi_digit_seg_ctrl;

    localparam int N   = 4;
    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] val_in;
    logic [3:0]  dot_in;
    logic [3:0]  blank_in;
    logic [2:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic        frame_tick;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    multi_digit_seg_ctrl #(.NUM_DIGITS(N), .CLK_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .val_in     (val_in),
        .dot_in     (dot_in),
        .blank_in   (blank_in),
        .brightness (brightness),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .busy       (busy),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Hand-written glyph table, active-low a..g.
    function automatic logic [6:0] exp_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic [3:0] exp_an(input int slot);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << slot);
    endfunction

    task automatic wait_frame_tick(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 200);
        assert_cnt++;
        if (frame_tick !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL %s frame_tick_timeout: tick=%b after %0d cycles, expected 1", tag, frame_tick, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; val_in = '0; dot_in = '0; blank_in = '0; brightness = 3'd7;
        repeat (3) @(negedge clk);
        assert_cnt++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0 || frame_tick !== 1'b0) begin
            fail_cnt++;
            $display("[TB] FAIL reset_hold: an=%h seg=%b dp=%b busy=%b tick=%b, expected f 1111111 1 0 0", an, seg, dp, busy, frame_tick);
        end
        rst = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            assert_cnt++;
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0) begin
                fail_cnt++;
                $display("[TB] FAIL reset_dark cycle %0d: an=%h seg=%b dp=%b busy=%b, expected f 1111111 1 0", i, an, seg, dp, busy);
            end
            assert_cnt++;
            if (frame_tick !== (i == 64)) begin
                fail_cnt++;
                $display("[TB] FAIL reset_tick cycle %0d: tick=%b, expected %b", i, frame_tick, (i == 64));
            end
        end
    endtask

    task automatic test_basic_load();
        logic [15:0] v;
        logic [3:0]  d;
        v = 16'h8F30;
        d = 4'b0100;
        repeat (10) @(negedge clk);
        load = 1'b1; val_in = v; dot_in = d; blank_in = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        assert_cnt++;
        if (busy !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL basic_busy_set: busy=%b, expected 1", busy);
        end
        assert_cnt++;
        if (an !== 4'hF) begin
            fail_cnt++;
            $display("[TB] FAIL basic_no_early_swap: an=%h, expected f", an);
        end
        wait_frame_tick("basic");
        assert_cnt++;
        if (busy !== 1'b0) begin
            fail_cnt++;
            $display("[TB] FAIL basic_busy_clear: busy=%b, expected 0", busy);
        end
        for (int k = 0; k < 4; k++) begin
            repeat ((k == 0) ? 9 : 16) @(negedge clk);
            assert_cnt++;
            if (an !== exp_an(k) || seg !== exp_seg(v[k*4 +: 4]) || dp !== ~d[k]) begin
                fail_cnt++;
                $display("[TB] FAIL basic_slot%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                         k, an, seg, dp, exp_an(k), exp_seg(v[k*4 +: 4]), ~d[k]);
            end
        end
        wait_frame_tick("basic_end");
    endtask

    task automatic test_double_load();
        logic [15:0] v;
        v = 16'h2222;
        repeat (2) @(negedge clk);
        load = 1'b1; val_in = 16'h1111; dot_in = 4'b0000; blank_in = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        load = 1'b1; val_in = v;
        @(negedge clk);
        load = 1'b0;
        assert_cnt++;
        if (busy !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL double_busy: busy=%b, expected 1", busy);
        end
        wait_frame_tick("double");
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            assert_cnt++;
            if (an !== exp_an((i-1)/16) || seg !== exp_seg(v[((i-1)/16)*4 +: 4]) || dp !== 1'b1) begin
                fail_cnt++;
                $display("[TB] FAIL double_frame cycle %0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
                         i, an, seg, dp, exp_an((i-1)/16), exp_seg(v[((i-1)/16)*4 +: 4]));
            end
        end
        assert_cnt++;
        if (frame_tick !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL double_tick: tick=%b, expected 1", frame_tick);
        end
    endtask

    task automatic test_load_at_swap();
        logic [15:0] old_v;
        logic [15:0] new_v;
        logic [3:0]  new_d;
        old_v = 16'h2222;
        new_v = 16'hABCD;
        new_d = 4'b0001;
        repeat (3) @(negedge clk);
        load = 1'b1; val_in = 16'h4567; dot_in = 4'b0000; blank_in = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        repeat (59) @(negedge clk);
        load = 1'b1; val_in = new_v; dot_in = new_d;
        @(negedge clk);
        load = 1'b0;
        assert_cnt++;
        if (frame_tick !== 1'b1 || busy !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL swap_deferred: tick=%b busy=%b, expected tick=1 busy=1", frame_tick, busy);
        end
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            assert_cnt++;
            if (an !== exp_an((i-1)/16) || seg !== exp_seg(old_v[((i-1)/16)*4 +: 4]) || dp !== 1'b1) begin
                fail_cnt++;
                $display("[TB] FAIL swap_old_frame cycle %0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
                         i, an, seg, dp, exp_an((i-1)/16), exp_seg(old_v[((i-1)/16)*4 +: 4]));
            end
        end
        assert_cnt++;
        if (frame_tick !== 1'b1 || busy !== 1'b0) begin
            fail_cnt++;
            $display("[TB] FAIL swap_second_end: tick=%b busy=%b, expected tick=1 busy=0", frame_tick, busy);
        end
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            assert_cnt++;
            if (an !== exp_an((i-1)/16) || seg !== exp_seg(new_v[((i-1)/16)*4 +: 4]) || dp !== ~new_d[(i-1)/16]) begin
                fail_cnt++;
                $display("[TB] FAIL swap_new_frame cycle %0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                         i, an, seg, dp, exp_an((i-1)/16), exp_seg(new_v[((i-1)/16)*4 +: 4]), ~new_d[(i-1)/16]);
            end
        end
    endtask

    task automatic test_blank_and_reset();
        logic [15:0] v;
        logic [3:0]  b;
        logic [3:0]  ea;
        logic [6:0]  es;
        int          slot;
        v = 16'h1234;
        b = 4'b1010;
        repeat (2) @(negedge clk);
        load = 1'b1; val_in = v; dot_in = 4'b0000; blank_in = b;
        @(negedge clk);
        load = 1'b0;
        wait_frame_tick("blank");
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            slot = (i - 1) / 16;
            ea = b[slot] ? 4'hF : exp_an(slot);
            es = b[slot] ? 7'h7F : exp_seg(v[slot*4 +: 4]);
            assert_cnt++;
            if (an !== ea || seg !== es || dp !== 1'b1) begin
                fail_cnt++;
                $display("[TB] FAIL blank_frame cycle %0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1", i, an, seg, dp, ea, es);
            end
            if (i == 38) begin
                load = 1'b1; val_in = 16'hFFFF; blank_in = 4'b0000;
            end else if (i == 39) begin
                load = 1'b0;
                assert_cnt++;
                if (busy !== 1'b1) begin
                    fail_cnt++;
                    $display("[TB] FAIL blank_pending_before_reset: busy=%b, expected 1", busy);
                end
            end else if (i == 40) begin
                rst = 1'b1; load = 1'b1; val_in = 16'hEEEE;
            end
        end
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        assert_cnt++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0 || frame_tick !== 1'b0) begin
            fail_cnt++;
            $display("[TB] FAIL midframe_reset: an=%h seg=%b dp=%b busy=%b tick=%b, expected f 1111111 1 0 0", an, seg, dp, busy, frame_tick);
        end
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            assert_cnt++;
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0) begin
                fail_cnt++;
                $display("[TB] FAIL post_reset_dark cycle %0d: an=%h seg=%b dp=%b busy=%b, expected f 1111111 1 0", i, an, seg, dp, busy);
            end
            if (i == 64) begin
                assert_cnt++;
                if (frame_tick !== 1'b1) begin
                    fail_cnt++;
                    $display("[TB] FAIL post_reset_tick: tick=%b, expected 1", frame_tick);
                end
            end
        end
    endtask

    task automatic test_brightness();
        logic [3:0] ea;
        logic       on;
        brightness = 3'd1;
        load = 1'b1; val_in = 16'h0000; dot_in = 4'b0000; blank_in = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        wait_frame_tick("pwm");
        for (int pass = 0; pass < 2; pass++) begin
            brightness = (pass == 0) ? 3'd1 : 3'd7;
            for (int i = 1; i <= 64; i++) begin
                @(negedge clk);
`ifdef SEG_DIM_PWM_EN
                on = (pass == 1) || (((i - 1) % 16) < 4);
`else
                on = 1'b1;
`endif
                ea = on ? exp_an((i-1)/16) : 4'hF;
                assert_cnt++;
                if (an !== ea || seg !== (on ? 7'b0000001 : 7'h7F)) begin
                    fail_cnt++;
                    $display("[TB] FAIL pwm_level%0d cycle %0d: an=%b seg=%b, expected an=%b seg=%b",
                             brightness, i, an, seg, ea, (on ? 7'b0000001 : 7'h7F));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_double_load();
        test_load_at_swap();
        test_blank_and_reset();
        test_brightness();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
